// File: rtl/dcram_fill_seq.sv
// Data-cache line fill sequencer.
// Collects four 32-bit bus beats per 16-byte line, pairs them into big-endian
// doublewords and writes each doubleword into the data-cache RAM. Fill writes
// always take the RAM port from the pipeline. A bus error aborts the fill.
module dcram_fill_seq #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fill_req,
  input  logic [AW-1:0] fill_addr,
  input  logic [1:0]    fill_way,
  input  logic [31:0]   biu_data,
  input  logic          biu_ack,
  input  logic          biu_err,
  input  logic          pipe_req,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          fill_err,
  output logic          pipe_stall,
  output logic          dc_enable,
  output logic [3:0]    dc_we,
  output logic [AW-1:0] dc_addr,
  output logic [63:0]   dc_data_in,
  output logic [1:0]    dc_bank_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t         state;
  logic [AW-5:0]  line_q;   // line address, bits [AW-1:4]
  logic [1:0]     way_q;
  logic           dw;       // doubleword index within the line
  logic [31:0]    hi_q;     // upper word of the doubleword being assembled
  logic           wr_q;     // a write is presented this cycle
  logic [3:0]     we_q;

  // Fill sequencing and registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      line_q      <= '0;
      way_q       <= '0;
      dw          <= 1'b0;
      hi_q        <= '0;
      wr_q        <= 1'b0;
      we_q        <= '0;
      fill_done   <= 1'b0;
      fill_err    <= 1'b0;
      dc_addr     <= '0;
      dc_data_in  <= '0;
      dc_bank_sel <= '0;
    end else begin
      // NOTE: pulse outputs get a default here so every path that does not
      // raise them drops them after one cycle; state uses non-blocking
      // assignment so all registers see the same pre-edge values.
      wr_q      <= 1'b0;
      we_q      <= '0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_req) begin
            line_q <= fill_addr[AW-1:4];
            way_q  <= fill_way;
            dw     <= 1'b0;
            state  <= EVEN;
          end
        end
        EVEN: begin
          if (biu_err) begin
            state     <= IDLE;
            fill_done <= 1'b1;
            fill_err  <= 1'b1;
          end else if (biu_ack) begin
            hi_q  <= biu_data;
            state <= ODD;
          end
        end
        ODD: begin
          if (biu_err) begin
            // The captured upper word is simply never written.
            state     <= IDLE;
            fill_done <= 1'b1;
            fill_err  <= 1'b1;
          end else if (biu_ack) begin
            wr_q        <= 1'b1;
            we_q        <= 4'b1111;
            dc_addr     <= {line_q, dw, 3'b000};
            dc_data_in  <= {hi_q, biu_data};
            dc_bank_sel <= way_q;
            if (dw) begin
              state     <= IDLE;
              fill_done <= 1'b1;
            end else begin
              dw    <= 1'b1;
              state <= EVEN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fill_busy = (state != IDLE);

  // A write registered just before reset must not reach the RAM, so the
  // enables are masked by reset in the cycle it is asserted.
  assign dc_enable  = wr_q & ~reset;
  assign dc_we      = we_q & {4{~reset}};
  assign pipe_stall = dc_enable & pipe_req;

endmodule

// File: tb/tb_dcram_fill_seq.sv
// Self-checking bench for dcram_fill_seq. The driver issues line fills with
// random beat spacing, errors and pipeline requests, and records per-cycle
// expectations (writes, done/err pulses, busy) derived from the fill rules.
module tb_dcram_fill_seq;

  localparam int AW = 14;
  localparam int N  = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          fill_req;
  logic [AW-1:0] fill_addr;
  logic [1:0]    fill_way;
  logic [31:0]   biu_data;
  logic          biu_ack;
  logic          biu_err;
  logic          pipe_req;
  logic          fill_busy;
  logic          fill_done;
  logic          fill_err;
  logic          pipe_stall;
  logic          dc_enable;
  logic [3:0]    dc_we;
  logic [AW-1:0] dc_addr;
  logic [63:0]   dc_data_in;
  logic [1:0]    dc_bank_sel;

  always #5 clk = ~clk;

  dcram_fill_seq #(.AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_way    (fill_way),
    .biu_data    (biu_data),
    .biu_ack     (biu_ack),
    .biu_err     (biu_err),
    .pipe_req    (pipe_req),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .fill_err    (fill_err),
    .pipe_stall  (pipe_stall),
    .dc_enable   (dc_enable),
    .dc_we       (dc_we),
    .dc_addr     (dc_addr),
    .dc_data_in  (dc_data_in),
    .dc_bank_sel (dc_bank_sel)
  );

  int cyc;
  int n_checks;
  int n_errors;
  bit hold_pipe;

  // Expected behaviour per cycle index.
  logic          exp_wr   [N];
  logic [AW-1:0] exp_addr [N];
  logic [63:0]   exp_data [N];
  logic [1:0]    exp_bank [N];
  logic          exp_done [N];
  logic          exp_err  [N];
  logic          exp_busy [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_cycle();
    check("dc_enable", 64'(dc_enable), 64'(exp_wr[cyc]));
    check("dc_we", 64'(dc_we), exp_wr[cyc] ? 64'hF : 64'h0);
    if (exp_wr[cyc]) begin
      check("dc_addr", 64'(dc_addr), 64'(exp_addr[cyc]));
      check("dc_data_in", dc_data_in, exp_data[cyc]);
      check("dc_bank_sel", 64'(dc_bank_sel), 64'(exp_bank[cyc]));
    end
    check("fill_done", 64'(fill_done), 64'(exp_done[cyc]));
    if (exp_done[cyc]) check("fill_err", 64'(fill_err), 64'(exp_err[cyc]));
    check("fill_busy", 64'(fill_busy), 64'(exp_busy[cyc]));
    check("pipe_stall", 64'(pipe_stall), 64'(exp_wr[cyc] & pipe_req));
  endtask

  // Check the current cycle, advance one clock, then give inputs idle defaults.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    fill_req  = 1'b0;
    biu_ack   = 1'b0;
    biu_err   = 1'b0;
    biu_data  = $urandom;
    fill_addr = AW'($urandom);
    fill_way  = 2'($urandom);
    pipe_req  = hold_pipe ? 1'b1 : 1'($urandom);
  endtask

  // Idle cycles with bus noise that the sequencer must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      biu_ack = 1'($urandom);
      biu_err = 1'($urandom);
      tick();
    end
  endtask

  // One line fill. err_beat >= 4 means no error; gap < 0 means random spacing.
  task automatic run_fill(input logic [AW-1:0] addr, input logic [1:0] way,
                          input logic [3:0][31:0] beats, input int err_beat,
                          input bit err_with_ack, input int gap);
    logic [AW-1:0] base;
    int g;
    base      = {addr[AW-1:4], 4'h0};
    fill_req  = 1'b1;
    fill_addr = addr;
    fill_way  = way;
    tick();
    for (int k = 0; k < 4; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < g; i++) begin
        exp_busy[cyc] = 1'b1;
        fill_req = 1'($urandom);
        tick();
      end
      exp_busy[cyc] = 1'b1;
      fill_req = 1'($urandom);
      biu_data = beats[k];
      if (k == err_beat) begin
        biu_err = 1'b1;
        biu_ack = err_with_ack;
        exp_done[cyc+1] = 1'b1;
        exp_err[cyc+1]  = 1'b1;
        tick();
        return;
      end
      biu_ack = 1'b1;
      if (k % 2 == 1) begin
        exp_wr[cyc+1]   = 1'b1;
        exp_addr[cyc+1] = base + AW'((k / 2) * 8);
        exp_data[cyc+1] = {beats[k-1], beats[k]};
        exp_bank[cyc+1] = way;
      end
      if (k == 3) exp_done[cyc+1] = 1'b1;
      tick();
    end
  endtask

  // Reset in the cycle the first doubleword write would appear.
  task automatic reset_mid_fill();
    fill_req  = 1'b1;
    fill_addr = AW'(14'h1230);
    fill_way  = 2'd1;
    tick();
    exp_busy[cyc] = 1'b1;
    biu_ack  = 1'b1;
    biu_data = 32'h1111_0000;
    tick();
    exp_busy[cyc] = 1'b1;
    biu_ack  = 1'b1;
    biu_data = 32'h2222_0000;
    tick();
    exp_busy[cyc] = 1'b1;
    reset    = 1'b1;
    pipe_req = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_dc_addr", 64'(dc_addr), 64'h0);
    check("rst_dc_data_in", dc_data_in, 64'h0);
    check("rst_dc_bank_sel", 64'(dc_bank_sel), 64'h0);
    idle(2);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    hold_pipe = 1'b0;
    cyc       = 0;
    for (int i = 0; i < N; i++) begin
      exp_wr[i]   = 1'b0;
      exp_addr[i] = '0;
      exp_data[i] = '0;
      exp_bank[i] = '0;
      exp_done[i] = 1'b0;
      exp_err[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
    reset     = 1'b1;
    fill_req  = 1'b1;
    fill_addr = '0;
    fill_way  = '0;
    biu_data  = '0;
    biu_ack   = 1'b1;
    biu_err   = 1'b0;
    pipe_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    fill_req = 1'b0;
    biu_ack  = 1'b0;

    check("rst_fill_busy", 64'(fill_busy), 64'h0);
    check("rst_fill_done", 64'(fill_done), 64'h0);
    check("rst_fill_err", 64'(fill_err), 64'h0);
    check("rst_dc_enable", 64'(dc_enable), 64'h0);
    check("rst_dc_we", 64'(dc_we), 64'h0);
    check("rst_pipe_stall", 64'(pipe_stall), 64'h0);
    check("rst_addr0", 64'(dc_addr), 64'h0);
    check("rst_data0", dc_data_in, 64'h0);
    check("rst_bank0", 64'(dc_bank_sel), 64'h0);

    // Back-to-back beats.
    run_fill(AW'(14'h1230), 2'd2, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4, 1'b0, 0);
    idle(2);
    // Two idle cycles between beats.
    run_fill(AW'(14'h1230), 2'd2, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4, 1'b0, 2);
    idle(2);
    // Bus error together with the third beat.
    run_fill(AW'(14'h1230), 2'd2, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2, 1'b1, 0);
    idle(2);
    // Pipeline requesting the port throughout a fill.
    hold_pipe = 1'b1;
    pipe_req  = 1'b1;
    run_fill(AW'(14'h0A5C), 2'd3, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4, 1'b0, -1);
    idle(1);
    hold_pipe = 1'b0;
    idle(1);
    // Reset cancels a registered write.
    reset_mid_fill();
    // New fill requested in the fill_done cycle.
    run_fill(AW'(14'h2F47), 2'd1, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4, 1'b0, 1);
    run_fill(AW'(14'h3FF0), 2'd0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4, 1'b0, 0);
    idle(2);

    for (int f = 0; f < 40; f++) begin
      run_fill(AW'($urandom), 2'($urandom),
               {$urandom, $urandom, $urandom, $urandom},
               int'($urandom_range(0, 9)), 1'($urandom), -1);
      if ($urandom % 2 == 1) idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcram_fill_seq.md
DCRAM_FILL_SEQ -- requirements
Module: dcram_fill_seq

Interface
REQ-001 SHALL have parameter AW, default 14, meaning the byte-address width of the data-cache RAM port (`dc_msb+1).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port fill_req, input, 1 bit: start a line fill; sampled only in IDLE.
REQ-005 SHALL have port fill_addr, input, AW bits: line address; bits [3:0] ignored (16-byte line).
REQ-006 SHALL have port fill_way, input, 2 bits: target bank, forwarded to dc_bank_sel.
REQ-007 SHALL have port biu_data, input, 32 bits: fill beat data.
REQ-008 SHALL have port biu_ack, input, 1 bit: biu_data valid this cycle.
REQ-009 SHALL have port biu_err, input, 1 bit: bus error; aborts the fill.
REQ-010 SHALL have port pipe_req, input, 1 bit: pipeline requests the dcram port this cycle.
REQ-011 SHALL have port fill_busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port fill_done, output, 1 bit: one-cycle pulse at fill completion or abort.
REQ-013 SHALL have port fill_err, output, 1 bit: qualifies fill_done; 1 means aborted.
REQ-014 SHALL have port pipe_stall, output, 1 bit: pipe_req lost arbitration to a fill write.
REQ-015 SHALL have port dc_enable, output, 1 bit: dcram enable for a fill write.
REQ-016 SHALL have port dc_we, output, 4 bits: dcram write enables.
REQ-017 SHALL have port dc_addr, output, AW bits: dcram byte address of the write.
REQ-018 SHALL have port dc_data_in, output, 64 bits: dcram write data.
REQ-019 SHALL have port dc_bank_sel, output, 2 bits: dcram bank select.

Function
REQ-020 SHALL implement states IDLE, EVEN, ODD; beats arrive in address order, 4 beats per line, no critical-word-first.
REQ-021 SHALL, in IDLE with fill_req=1, latch fill_addr[AW-1:4], fill_way, clear the doubleword index dw, and enter EVEN next cycle.
REQ-022 SHALL, in EVEN with biu_ack=1, capture biu_data as the upper word (dc_data_in[63:32], big-endian) and enter ODD.
REQ-023 SHALL, in ODD with biu_ack=1, capture biu_data as the lower word (dc_data_in[31:0]) and register a write for the following cycle.
REQ-024 SHALL present the registered write exactly one cycle after the ODD ack: dc_enable=1, dc_we=4'b1111, dc_addr={line,dw,3'b000}, dc_bank_sel=latched way; all four for exactly one cycle.
REQ-025 SHALL, after an ODD ack with dw=0, set dw=1 and return to EVEN; the write cycle SHALL overlap EVEN so a biu_ack in that cycle is captured (back-to-back beats, no bubble).
REQ-026 SHALL, after an ODD ack with dw=1, return to IDLE, and pulse fill_done=1, fill_err=0 in the same cycle as the second write.
REQ-027 SHALL hold dc_enable=0, dc_we=0 in every cycle without a registered write; dc_addr/dc_data_in hold last value.
REQ-028 SHALL drive pipe_stall = (write presented this cycle) AND pipe_req; fill writes always win the port.
REQ-029 SHALL, on biu_err in EVEN or ODD, discard any partially captured doubleword, return to IDLE, and pulse fill_done=1, fill_err=1 next cycle.
REQ-030 SHALL complete a write already registered when biu_err arrives; no write SHALL be issued after the abort.
REQ-031 SHALL give biu_err priority over biu_ack in the same cycle.
REQ-032 SHALL ignore fill_req outside IDLE and biu_ack/biu_err in IDLE.
REQ-033 SHALL permit a new fill_req in the cycle fill_done pulses (state is IDLE then), entering EVEN next cycle.

Reset
REQ-034 SHALL, when reset=1 at a clock edge, enter IDLE, dw=0, fill_busy=0, fill_done=0, fill_err=0, pipe_stall=0, dc_enable=0, dc_we=0, dc_addr=0, dc_data_in=0, dc_bank_sel=0.
REQ-035 SHALL give reset priority over all inputs, including fill_req, and cancel any registered but unissued write.

Verification
REQ-036 Fill fill_addr=0x1230, way=2, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> writes {A0,A1}@0x1230 and {A2,A3}@0x1238, we=F, bank_sel=2, fill_done on 2nd write, fill_err=0.
REQ-037 Same fill with 2 idle cycles between every beat -> identical two writes, each one cycle after its odd beat, no extra dc_we cycles.
REQ-038 biu_err together with the 3rd beat -> exactly one write (@0x1230), fill_done=1 fill_err=1 next cycle, state IDLE.
REQ-039 pipe_req=1 held throughout a fill -> pipe_stall=1 in exactly the two write cycles, 0 otherwise.
REQ-040 reset asserted the cycle after the 2nd beat ack -> no write issued, all outputs 0, fill_busy=0 next cycle.
REQ-041 fill_req asserted mid-fill and again on the fill_done cycle -> first ignored, second starts a new fill next cycle.
